// File: rtl/ws2812_pixbuf_if.sv
// Pixel buffer bundle: producer write/commit port plus the driver's address/colour port.
// Purely combinational wiring; no latency and no backpressure of its own.
interface ws2812_pixbuf_if #(
  parameter int ADDR_W = 3
);
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [23:0]       wr_data;
  logic              commit;
  logic              busy;
  logic              swapped;
  logic [ADDR_W-1:0] address;
  logic              new_address;
  logic [7:0]        red;
  logic [7:0]        green;
  logic [7:0]        blue;

  modport master (
    output wr_en, wr_addr, wr_data, commit, address, new_address,
    input  busy, swapped, red, green, blue
  );

  modport slave (
    input  wr_en, wr_addr, wr_data, commit, address, new_address,
    output busy, swapped, red, green, blue
  );
endinterface

// File: rtl/ws2812_pixbuf.sv
// Double-buffered ws2812 pixel store; back bank swaps to front only at driver address 0.
// Read latency 1 cycle (2 with WS2812_PIXBUF_GAMMA_EN); writes dropped while busy (commit pending).
module ws2812_pixbuf #(
  parameter int NUM_LEDS = 8,
  parameter int ADDR_W   = 3
) (
  input logic        clk,
  input logic        reset,
  ws2812_pixbuf_if.slave bus
);
  localparam logic [ADDR_W:0] LIMIT = (ADDR_W + 1)'(NUM_LEDS);

  logic [23:0] mem [2][NUM_LEDS];
  logic        front_sel;
  logic        pending;
  logic        swapped_q;
  logic [23:0] pix_q;

  logic        wr_ok;
  logic        rd_ok;
  logic        swap_ev;
  logic        rd_bank;
  logic [23:0] rd_pix;

  assign wr_ok   = bus.wr_en && !pending && ({1'b0, bus.wr_addr} < LIMIT);
  assign rd_ok   = {1'b0, bus.address} < LIMIT;
  assign swap_ev = bus.new_address && (bus.address == '0) && pending;
  // Pixel 0 of the swap cycle already comes from the newly presented bank.
  assign rd_bank = front_sel ^ swap_ev;
  assign rd_pix  = rd_ok ? mem[rd_bank][bus.address] : 24'h0;

  always_ff @(posedge clk) begin
    if (wr_ok) begin
      mem[~front_sel][bus.wr_addr] <= bus.wr_data;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      front_sel <= 1'b0;
      pending   <= 1'b0;
      swapped_q <= 1'b0;
    end else begin
      swapped_q <= swap_ev;
      if (swap_ev) begin
        front_sel <= ~front_sel;
        pending   <= bus.commit;
      end else if (bus.commit) begin
        pending <= 1'b1;
      end
    end
  end

`ifdef WS2812_PIXBUF_GAMMA_EN
  logic [23:0] raw_q;
  logic        raw_vld;

  function automatic logic [7:0] gamma(input logic [7:0] c);
    logic [15:0] p;
    p = ({8'h00, c} * {8'h00, c}) + {8'h00, c};
    return p[15:8];
  endfunction

  always_ff @(posedge clk) begin
    if (reset) begin
      raw_q   <= 24'h0;
      raw_vld <= 1'b0;
      pix_q   <= 24'h0;
    end else begin
      raw_vld <= bus.new_address;
      if (bus.new_address) begin
        raw_q <= rd_pix;
      end
      if (raw_vld) begin
        pix_q <= {gamma(raw_q[23:16]), gamma(raw_q[15:8]), gamma(raw_q[7:0])};
      end
    end
  end
`else
  always_ff @(posedge clk) begin
    if (reset) begin
      pix_q <= 24'h0;
    end else if (bus.new_address) begin
      pix_q <= rd_pix;
    end
  end
`endif

  assign bus.busy    = pending;
  assign bus.swapped = swapped_q;
  assign bus.red     = pix_q[23:16];
  assign bus.green   = pix_q[15:8];
  assign bus.blue    = pix_q[7:0];
endmodule

// File: tb/tb_ws2812_pixbuf.sv
// Bench for ws2812_pixbuf: 8-LED and 6-LED instances, pixel reads checked through a scoreboard.
// Control outputs (busy/swapped) and reset state are checked directly from the stimulus thread.
`timescale 1ns/1ps
module tb_ws2812_pixbuf;
`ifdef WS2812_PIXBUF_GAMMA_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #10 clk = ~clk;

  ws2812_pixbuf_if #(.ADDR_W(3)) b8 ();
  ws2812_pixbuf_if #(.ADDR_W(3)) b6 ();

  ws2812_pixbuf #(.NUM_LEDS(8), .ADDR_W(3)) dut8 (.clk(clk), .reset(reset), .bus(b8));
  ws2812_pixbuf #(.NUM_LEDS(6), .ADDR_W(3)) dut6 (.clk(clk), .reset(reset), .bus(b6));

  int n_chk  = 0;
  int n_pass = 0;

  logic [23:0] q8[$];
  logic [23:0] q6[$];
  logic [1:0]  sr8 = 2'b00;
  logic [1:0]  sr6 = 2'b00;

  task automatic check(input string name, input logic [23:0] got, input logic [23:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, got, exp);
  endtask

`ifdef WS2812_PIXBUF_GAMMA_EN
  function automatic logic [7:0] g(input logic [7:0] c);
    logic [15:0] p;
    p = ({8'h00, c} * {8'h00, c}) + {8'h00, c};
    return p[15:8];
  endfunction
`endif

  function automatic logic [23:0] xf(input logic [23:0] p);
`ifdef WS2812_PIXBUF_GAMMA_EN
    return {g(p[23:16]), g(p[15:8]), g(p[7:0])};
`else
    return p;
`endif
  endfunction

  function automatic logic [23:0] pa(input int i);
    logic [7:0] k;
    k = 8'(i);
    return {k, 8'h10 + k, 8'h20 + k};
  endfunction

  function automatic logic [23:0] pb(input int i);
    logic [7:0] k;
    k = 8'(i);
    return {8'h80 + k, 8'h90 + k, 8'hA0 + k};
  endfunction

  function automatic logic [23:0] pc(input int i);
    logic [7:0] k;
    k = 8'(i);
    return {8'h40 + k, 8'h50 + k, 8'h60 + k};
  endfunction

  // Request history: a read result is due LAT edges after new_address was sampled.
  always @(posedge clk) begin
    sr8 <= {sr8[0], b8.new_address};
    sr6 <= {sr6[0], b6.new_address};
  end

  always @(negedge clk) begin
    if (sr8[LAT-1]) begin
      if (q8.size() == 0) begin
        n_chk++;
        $display("FAIL pix8: output %h with no expected entry", {b8.red, b8.green, b8.blue});
      end else begin
        check("pix8", {b8.red, b8.green, b8.blue}, q8.pop_front());
      end
    end
    if (sr6[LAT-1]) begin
      if (q6.size() == 0) begin
        n_chk++;
        $display("FAIL pix6: output %h with no expected entry", {b6.red, b6.green, b6.blue});
      end else begin
        check("pix6", {b6.red, b6.green, b6.blue}, q6.pop_front());
      end
    end
  end

  task automatic wr8(input int a, input logic [23:0] d);
    b8.wr_en = 1'b1; b8.wr_addr = 3'(a); b8.wr_data = d;
    @(negedge clk);
    b8.wr_en = 1'b0;
  endtask

  task automatic wr6(input int a, input logic [23:0] d);
    b6.wr_en = 1'b1; b6.wr_addr = 3'(a); b6.wr_data = d;
    @(negedge clk);
    b6.wr_en = 1'b0;
  endtask

  task automatic rd8(input int a, input logic [23:0] exp, input logic cm);
    q8.push_back(exp);
    b8.address = 3'(a); b8.new_address = 1'b1; b8.commit = cm;
    @(negedge clk);
    b8.new_address = 1'b0; b8.commit = 1'b0;
  endtask

  task automatic rd6(input int a, input logic [23:0] exp);
    q6.push_back(exp);
    b6.address = 3'(a); b6.new_address = 1'b1;
    @(negedge clk);
    b6.new_address = 1'b0;
  endtask

  task automatic commit8();
    b8.commit = 1'b1;
    @(negedge clk);
    b8.commit = 1'b0;
  endtask

  task automatic commit6();
    b6.commit = 1'b1;
    @(negedge clk);
    b6.commit = 1'b0;
  endtask

  initial begin
    b8.wr_en = 0; b8.wr_addr = 0; b8.wr_data = 0; b8.commit = 0; b8.address = 0; b8.new_address = 0;
    b6.wr_en = 0; b6.wr_addr = 0; b6.wr_data = 0; b6.commit = 0; b6.address = 0; b6.new_address = 0;

    repeat (3) @(negedge clk);
    check("rst_busy", 24'(b8.busy), 24'h0);
    check("rst_swapped", 24'(b8.swapped), 24'h0);
    check("rst_rgb", {b8.red, b8.green, b8.blue}, 24'h0);
    reset = 1'b0;
    @(negedge clk);

    // 6-LED instance: out-of-range writes ignored, out-of-range reads give 0.
    for (int i = 0; i < 6; i++) wr6(i, pc(i));
    wr6(6, 24'hFFFFFF);
    wr6(7, 24'hFFFFFF);
    commit6();
    check("busy6_commit", 24'(b6.busy), 24'h1);
    rd6(0, xf(pc(0)));
    check("swapped6", 24'(b6.swapped), 24'h1);
    rd6(5, xf(pc(5)));
    rd6(7, 24'h0);
    rd6(6, 24'h0);
    rd6(3, xf(pc(3)));
    repeat (3) @(negedge clk);
    check("hold6", {b6.red, b6.green, b6.blue}, xf(pc(3)));

    // Frame A into bank 1, swap at address 0.
    for (int i = 0; i < 8; i++) wr8(i, pa(i));
    commit8();
    check("busy_commit", 24'(b8.busy), 24'h1);
    rd8(0, xf(pa(0)), 1'b0);
    check("swapped_a", 24'(b8.swapped), 24'h1);
    check("busy_after_swap", 24'(b8.busy), 24'h0);
    rd8(1, xf(pa(1)), 1'b0);
    check("swapped_one_cycle", 24'(b8.swapped), 24'h0);
    for (int i = 2; i < 8; i++) rd8(i, xf(pa(i)), 1'b0);
    repeat (3) @(negedge clk);
    check("hold8", {b8.red, b8.green, b8.blue}, xf(pa(7)));

    // Frame B into bank 0; write while busy is dropped.
    for (int i = 0; i < 8; i++) wr8(i, pb(i));
    commit8();
    check("busy_b", 24'(b8.busy), 24'h1);
    wr8(3, 24'hFFFFFF);
    rd8(0, xf(pb(0)), 1'b0);
    rd8(3, xf(pb(3)), 1'b0);
    commit8();
    rd8(0, xf(pa(0)), 1'b0);
    rd8(3, xf(pa(3)), 1'b0);

    // Commit coincident with the swap re-arms: two consecutive swaps.
    commit8();
    rd8(0, xf(pb(0)), 1'b1);
    check("swapped_rearm", 24'(b8.swapped), 24'h1);
    check("busy_rearm", 24'(b8.busy), 24'h1);
    rd8(0, xf(pa(0)), 1'b0);
    check("swapped_second", 24'(b8.swapped), 24'h1);
    check("busy_second", 24'(b8.busy), 24'h0);
    rd8(0, xf(pa(0)), 1'b0);
    check("no_swap_idle", 24'(b8.swapped), 24'h0);
    rd8(5, xf(pa(5)), 1'b0);

    // Partial back-bank update plus the gamma probe pixel.
    wr8(2, 24'h123456);
    wr8(4, 24'hFF8001);
    commit8();
    rd8(0, xf(pb(0)), 1'b0);
    rd8(2, xf(24'h123456), 1'b0);
`ifdef WS2812_PIXBUF_GAMMA_EN
    rd8(4, 24'hFF4000, 1'b0);
`else
    rd8(4, 24'hFF8001, 1'b0);
`endif

    // Reset with a commit pending: front returns to bank 0, commit discarded.
    commit8();
    rd8(0, xf(pa(0)), 1'b0);
    commit8();
    check("busy_pre_reset", 24'(b8.busy), 24'h1);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    check("reset_busy", 24'(b8.busy), 24'h0);
    check("reset_swapped", 24'(b8.swapped), 24'h0);
    check("reset_rgb", {b8.red, b8.green, b8.blue}, 24'h0);
    reset = 1'b0;
    rd8(0, xf(pb(0)), 1'b0);
    check("post_reset_no_swap", 24'(b8.swapped), 24'h0);
    check("post_reset_busy", 24'(b8.busy), 24'h0);
    rd8(2, xf(24'h123456), 1'b0);

    repeat (4) @(negedge clk);
    check("q8_drained", 24'(q8.size()), 24'h0);
    check("q6_drained", 24'(q6.size()), 24'h0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
